wb_regfile: RTL and testbench
=============================

# wb_regfile

Parametrised write-back stage for the pipelined Y86-64 core. It combines the W pipeline register (with stall and bubble control), a multi-read-port register file with two write ports (E and M), write-through bypass, and a halt state machine. The halt FSM stops architectural updates on the first exceptional status. The block sits after the memory stage and feeds decode-stage reads and forwarding.

## Interface

- XLEN, 64, data width of each register
- NREG, 15, number of architectural registers (at most 2^RADDR − 1)
- RADDR, 4, register-address width
- NRD, 2, number of read ports
- BYPASS, 1, 1 = reads see same-cycle W writes; 0 = reads see stored value only
- CNTW, 32, width of the retired-instruction counter

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high
- w_stall  in  1  hold W register; suppress write and count
- w_bubble  in  1  load bubble into W register
- m_stat  in  3  status from M stage
- m_icode  in  4  icode from M stage
- m_valE, m_valM  in  XLEN each  results from M stage
- m_dstE, m_dstM  in  RADDR each  destinations from M stage; all-ones = none (RNONE)
- rd_addr  in  NRD*RADDR  read address, port k at [k*RADDR +: RADDR]
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN]
- W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  as above  W register contents, used for forwarding
- halted  out  1  FSM in HALTED
- exc_code  out  3  status that caused the halt; 0 while running
- retired  out  CNTW  count of retired AOK instructions
- regs_flat  out  NREG*XLEN  debug dump, register i at [i*XLEN +: XLEN]

## Operation

- Status codes are BUB=0, AOK=1, HLT=2, ADR=3, INS=4. NOP icode = 1.
- W register update on each edge:
  - w_stall=1: hold, regardless of w_bubble.
  - Else w_bubble=1: load stat=BUB, icode=NOP, valE=valM=0, dstE=dstM=RNONE.
  - Else: load the m_* inputs.
- Write enable: we = (FSM==RUN) & !w_stall & (W_stat==AOK).
  - When we=1, W_valE is written to W_dstE and W_valM is written to W_dstM.
  - A destination equal to RNONE, or ≥ NREG, is ignored.
  - If W_dstE==W_dstM (valid), W_valM wins, as in popq %rsp.
- Retired counter: increments by 1 when we=1, whether or not any destination is valid. It wraps modulo 2^CNTW.
- FSM states:
  - RUN → HALTED when FSM==RUN, !w_stall, and W_stat ∈ {HLT, ADR, INS}. On that transition exc_code is latched to W_stat.
  - The exceptional instruction performs no write and is not counted.
  - HALTED persists until reset. No writes and no counting occur in HALTED. The W register still follows the stall/bubble rules.
  - A W_stat outside 0–4 is treated as INS.
- Read port k:
  - If the address is ≥ NREG or equal to RNONE, rd_data is 0.
  - Else if BYPASS and we and the address matches a valid W_dstM, rd_data is W_valM.
  - Else if BYPASS and we and the address matches a valid W_dstE, rd_data is W_valE.
  - Else rd_data is the stored register.
  - Read ports are purely combinational.

## Timing

- Reset values:
  - All registers 0.
  - W register holds a bubble (W_stat=0, W_icode=1, values 0, destinations RNONE).
  - FSM=RUN, halted=0, exc_code=0, retired=0.
- Reset is asynchronous: asserting it mid-operation clears all state immediately. A write in flight that cycle is lost.
- Latency:
  - m_* inputs appear on W_* one edge after capture.
  - The register write happens at the following edge, so stored values are visible two edges after capture.
  - With BYPASS=1, the new value is visible on rd_data during the cycle it sits in W.
- halted and exc_code assert on the same edge that would have written the exceptional instruction.
- Simultaneous w_stall and w_bubble: stall wins, with no write and no count.
- regs_flat reflects stored state only; bypass does not apply to it.

## Test plan

- **Reset, then idle.** Reset, then 5 idle cycles with bubbles. Required: all rd_data=0, retired=0, halted=0, W_icode=1.
- **Single write, both modes.** Capture AOK, dstE=3, valE=0x1234, dstM=RNONE. Required: rd_addr=3 reads 0x1234 in the W cycle with BYPASS=1. Stored value is visible on the next edge. retired=1.
- **Same-destination conflict.** Capture AOK with dstE=dstM=4, valE=0xAA, valM=0xBB. Required: register 4 = 0xBB; a bypass read in the same cycle returns 0xBB.
- **Stall suppression.** Hold w_stall=1 for 3 cycles with an AOK write in W. Required: no write and retired unchanged until stall drops, then exactly one write and retired+1.
- **Halt.** Capture HLT with dstE=2, valE=0x55. Required: register 2 unchanged, halted=1, exc_code=2. Subsequent AOK writes are ignored and retired is frozen.
- **Out-of-range and reset recovery.** Write to dst=14 with NREG=14; read address 15. Required: no register changes, rd_data=0. Then assert reset mid-halt. Required: halted=0, exc_code=0, all registers 0.

Source files
------------

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage of the pipelined Y86-64 core.
// It holds the W pipeline register, which supports stall and bubble. It also
// holds a register file with one E and one M write port, optional
// write-through bypass on the read ports, and a RUN/HALTED state machine that
// freezes architectural updates after the first exceptional status.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   w_stall, w_bubble    W register control (stall wins over bubble)
//   m_stat .. m_dstM     instruction fields arriving from the M stage
//   rd_addr / rd_data    NRD combinational read ports, packed per port
//   W_stat .. W_dstM     current W register contents (forwarding sources)
//   halted, exc_code     FSM state and the status that caused the halt
//   retired              count of retired AOK instructions (wraps)
//   regs_flat            stored register contents, register i at [i*XLEN +: XLEN]
module wb_regfile #(
    parameter int XLEN   = 64,
    parameter int NREG   = 15,
    parameter int RADDR  = 4,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int CNTW   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  w_stall,
    input  logic                  w_bubble,
    input  logic [2:0]            m_stat,
    input  logic [3:0]            m_icode,
    input  logic [XLEN-1:0]       m_valE,
    input  logic [XLEN-1:0]       m_valM,
    input  logic [RADDR-1:0]      m_dstE,
    input  logic [RADDR-1:0]      m_dstM,
    input  logic [NRD*RADDR-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [2:0]            W_stat,
    output logic [3:0]            W_icode,
    output logic [XLEN-1:0]       W_valE,
    output logic [XLEN-1:0]       W_valM,
    output logic [RADDR-1:0]      W_dstE,
    output logic [RADDR-1:0]      W_dstM,
    output logic                  halted,
    output logic [2:0]            exc_code,
    output logic [CNTW-1:0]       retired,
    output logic [NREG*XLEN-1:0]  regs_flat
);

    localparam logic [2:0]       ST_BUB = 3'd0;
    localparam logic [2:0]       ST_AOK = 3'd1;
    localparam logic [2:0]       ST_INS = 3'd4;
    localparam logic [3:0]       I_NOP  = 4'd1;
    localparam logic [RADDR-1:0] RNONE  = '1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t          state;
    logic [XLEN-1:0] regs [NREG];
    logic            we;
    logic            dste_ok;
    logic            dstm_ok;
    logic            stat_exc;

    // A register address names real storage only if it is not RNONE and lies
    // below NREG.
    function automatic logic addr_ok(input logic [RADDR-1:0] a);
        return (a != RNONE) && (int'(a) < NREG);
    endfunction

    assign we       = (state == RUN) && !w_stall && (W_stat == ST_AOK);
    assign dste_ok  = addr_ok(W_dstE);
    assign dstm_ok  = addr_ok(W_dstM);
    // Anything other than BUB or AOK stops the machine, including the
    // undefined codes 5..7.
    assign stat_exc = (W_stat != ST_BUB) && (W_stat != ST_AOK);
    assign halted   = (state == HALTED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            W_stat   <= ST_BUB;
            W_icode  <= I_NOP;
            W_valE   <= '0;
            W_valM   <= '0;
            W_dstE   <= RNONE;
            W_dstM   <= RNONE;
            state    <= RUN;
            exc_code <= '0;
            retired  <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            if (!w_stall) begin
                if (w_bubble) begin
                    W_stat  <= ST_BUB;
                    W_icode <= I_NOP;
                    W_valE  <= '0;
                    W_valM  <= '0;
                    W_dstE  <= RNONE;
                    W_dstM  <= RNONE;
                end else begin
                    W_stat  <= m_stat;
                    W_icode <= m_icode;
                    W_valE  <= m_valE;
                    W_valM  <= m_valM;
                    W_dstE  <= m_dstE;
                    W_dstM  <= m_dstM;
                end
            end

            if (we) begin
                retired <= retired + CNTW'(1);
                // The M write comes second so that it wins when both ports
                // target the same register (popq %rsp).
                for (int i = 0; i < NREG; i++) begin
                    if (dste_ok && (W_dstE == RADDR'(i))) regs[i] <= W_valE;
                    if (dstm_ok && (W_dstM == RADDR'(i))) regs[i] <= W_valM;
                end
            end

            if ((state == RUN) && !w_stall && stat_exc) begin
                state    <= HALTED;
                exc_code <= (W_stat > ST_INS) ? ST_INS : W_stat;
            end
        end
    end

    // Read ports. The bypass is qualified by we, so a stalled, halted or
    // non-AOK W entry is never forwarded.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [RADDR-1:0] a;
        logic [XLEN-1:0]  d;
        assign a = rd_addr[k*RADDR +: RADDR];
        always_comb begin
            d = '0;
            if (addr_ok(a)) begin
                if ((BYPASS != 0) && we && dstm_ok && (W_dstM == a))
                    d = W_valM;
                else if ((BYPASS != 0) && we && dste_ok && (W_dstE == a))
                    d = W_valE;
                else
                    d = regs[a];
            end
        end
        assign rd_data[k*XLEN +: XLEN] = d;
    end

    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign regs_flat[i*XLEN +: XLEN] = regs[i];
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile. Two instances share all inputs: dut has
// BYPASS=1 and dut_nb has BYPASS=0. Both use NREG=14, so that address 14 is
// out of range and address 15 is RNONE.
module tb_wb_regfile;

    localparam int XLEN  = 64;
    localparam int NREG  = 14;
    localparam int RADDR = 4;
    localparam int NRD   = 2;
    localparam int CNTW  = 32;
    localparam int FW    = NREG * XLEN;
    localparam logic [RADDR-1:0] RNONE = '1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 w_stall, w_bubble;
    logic [2:0]           m_stat;
    logic [3:0]           m_icode;
    logic [XLEN-1:0]      m_valE, m_valM;
    logic [RADDR-1:0]     m_dstE, m_dstM;
    logic [NRD*RADDR-1:0] rd_addr;

    logic [NRD*XLEN-1:0]  rd_data, nb_rd_data;
    logic [2:0]           W_stat, nb_W_stat;
    logic [3:0]           W_icode, nb_W_icode;
    logic [XLEN-1:0]      W_valE, W_valM, nb_W_valE, nb_W_valM;
    logic [RADDR-1:0]     W_dstE, W_dstM, nb_W_dstE, nb_W_dstM;
    logic                 halted, nb_halted;
    logic [2:0]           exc_code, nb_exc_code;
    logic [CNTW-1:0]      retired, nb_retired;
    logic [FW-1:0]        regs_flat, nb_regs_flat;

    logic [XLEN-1:0]      exp_regs [NREG];
    int                   n_checks = 0;
    int                   n_pass   = 0;

    wb_regfile #(.XLEN(XLEN), .NREG(NREG), .RADDR(RADDR), .NRD(NRD), .BYPASS(1), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .w_stall(w_stall), .w_bubble(w_bubble),
        .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_dstE(m_dstE), .m_dstM(m_dstM), .rd_addr(rd_addr), .rd_data(rd_data),
        .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
        .W_dstE(W_dstE), .W_dstM(W_dstM), .halted(halted), .exc_code(exc_code),
        .retired(retired), .regs_flat(regs_flat)
    );

    wb_regfile #(.XLEN(XLEN), .NREG(NREG), .RADDR(RADDR), .NRD(NRD), .BYPASS(0), .CNTW(CNTW)) dut_nb (
        .clk(clk), .reset(reset), .w_stall(w_stall), .w_bubble(w_bubble),
        .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_valE), .m_valM(m_valM),
        .m_dstE(m_dstE), .m_dstM(m_dstM), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .W_stat(nb_W_stat), .W_icode(nb_W_icode), .W_valE(nb_W_valE), .W_valM(nb_W_valM),
        .W_dstE(nb_W_dstE), .W_dstM(nb_W_dstM), .halted(nb_halted), .exc_code(nb_exc_code),
        .retired(nb_retired), .regs_flat(nb_regs_flat)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [FW-1:0] exp_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*XLEN +: XLEN] = exp_regs[i];
        return f;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [2:0] st, input logic [3:0] ic,
                       input logic [RADDR-1:0] de, input logic [XLEN-1:0] ve,
                       input logic [RADDR-1:0] dm, input logic [XLEN-1:0] vm);
        w_bubble = 1'b0;
        m_stat   = st;
        m_icode  = ic;
        m_dstE   = de;
        m_valE   = ve;
        m_dstM   = dm;
        m_valM   = vm;
    endtask

    task automatic idle();
        w_bubble = 1'b1;
        m_stat   = 3'd1;
        m_icode  = 4'd3;
        m_dstE   = 4'd7;
        m_valE   = 64'hFFFF;
        m_dstM   = RNONE;
        m_valM   = '0;
    endtask

    task automatic set_rd(input logic [RADDR-1:0] a0, input logic [RADDR-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
        reset   = 1'b1;
        w_stall = 1'b0;
        idle();
        rd_addr = '0;
        #12 reset = 1'b0;

        // Reset state.
        check("rst_retired", retired, 0);
        check("rst_halted", halted, 0);
        check("rst_exc", exc_code, 0);
        check("rst_W_icode", W_icode, 1);
        check("rst_W_stat", W_stat, 0);
        check("rst_W_dstE", W_dstE, RNONE);
        check("rst_flat", regs_flat, '0);

        // Five idle bubble cycles.
        repeat (5) tick();
        set_rd(4'd3, 4'd0);
        check("idle_rd0", rd_data[0 +: XLEN], 0);
        check("idle_rd1", rd_data[XLEN +: XLEN], 0);
        check("idle_retired", retired, 0);
        check("idle_halted", halted, 0);
        check("idle_W_icode", W_icode, 1);

        // Single write to r3.
        cap(3'd1, 4'd3, 4'd3, 64'h1234, RNONE, 64'h0);
        tick();
        idle();
        set_rd(4'd3, 4'd3);
        check("single_W_valE", W_valE, 64'h1234);
        check("single_byp_rd", rd_data[0 +: XLEN], 64'h1234);
        check("single_nobyp_rd", nb_rd_data[0 +: XLEN], 0);
        check("single_retired_pre", retired, 0);
        tick();
        exp_regs[3] = 64'h1234;
        check("single_byp_stored", rd_data[XLEN +: XLEN], 64'h1234);
        check("single_nobyp_stored", nb_rd_data[0 +: XLEN], 64'h1234);
        check("single_retired", retired, 1);
        check("single_flat", regs_flat, exp_flat());

        // Same-destination conflict: valM wins.
        cap(3'd1, 4'hB, 4'd4, 64'hAA, 4'd4, 64'hBB);
        tick();
        idle();
        set_rd(4'd3, 4'd4);
        check("conf_byp_rd", rd_data[XLEN +: XLEN], 64'hBB);
        check("conf_nobyp_rd", nb_rd_data[XLEN +: XLEN], 0);
        tick();
        exp_regs[4] = 64'hBB;
        check("conf_stored", nb_rd_data[XLEN +: XLEN], 64'hBB);
        check("conf_retired", retired, 2);
        check("conf_flat", regs_flat, exp_flat());

        // Stall suppression, with bubble also asserted (stall wins).
        cap(3'd1, 4'd6, 4'd5, 64'h77, RNONE, 64'h0);
        tick();
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        set_rd(4'd5, 4'd0);
        check("stall_byp_gated", rd_data[0 +: XLEN], 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_W_dstE", W_dstE, 4'd5);
            check("stall_retired", retired, 2);
            check("stall_flat", regs_flat, exp_flat());
        end
        w_stall = 1'b0;
        #1;
        check("unstall_byp_rd", rd_data[0 +: XLEN], 64'h77);
        tick();
        exp_regs[5] = 64'h77;
        check("unstall_retired", retired, 3);
        check("unstall_flat", regs_flat, exp_flat());
        check("unstall_W_stat", W_stat, 0);
        tick();
        check("bubble_not_counted", retired, 3);

        // Out-of-range destination and read addresses.
        cap(3'd1, 4'd3, 4'd14, 64'hDEAD, RNONE, 64'h0);
        tick();
        idle();
        set_rd(4'd14, 4'd15);
        check("oor_rd14", rd_data[0 +: XLEN], 0);
        check("oor_rd15", rd_data[XLEN +: XLEN], 0);
        tick();
        check("oor_flat", regs_flat, exp_flat());
        check("oor_retired", retired, 4);

        // Halt: the HLT instruction does not write, later AOKs are ignored.
        cap(3'd2, 4'd0, 4'd2, 64'h55, RNONE, 64'h0);
        tick();
        check("hlt_pre_halted", halted, 0);
        cap(3'd1, 4'd3, 4'd6, 64'h99, RNONE, 64'h0);
        tick();
        check("hlt_halted", halted, 1);
        check("hlt_exc", exc_code, 2);
        check("hlt_retired", retired, 4);
        check("hlt_flat", regs_flat, exp_flat());
        set_rd(4'd6, 4'd2);
        check("hlt_no_bypass", rd_data[0 +: XLEN], 0);
        idle();
        tick();
        check("hlt_after_flat", regs_flat, exp_flat());
        check("hlt_after_retired", retired, 4);
        check("hlt_W_bubble", W_stat, 0);
        check("hlt_nb_halted", nb_halted, 1);

        // Asynchronous reset while halted.
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
        check("rst2_halted", halted, 0);
        check("rst2_exc", exc_code, 0);
        check("rst2_retired", retired, 0);
        check("rst2_flat", regs_flat, '0);
        check("rst2_W_icode", W_icode, 1);
        tick();
        reset = 1'b0;

        // An undefined status code halts with exc_code INS.
        cap(3'd5, 4'd3, 4'd1, 64'h11, RNONE, 64'h0);
        tick();
        idle();
        tick();
        check("ins_halted", halted, 1);
        check("ins_exc", exc_code, 4);
        check("ins_flat", regs_flat, '0);
        check("ins_retired", retired, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
